// File: rtl/xrbus_tx_arbiter.sv
// Round-robin XR-BUS transmit arbiter: one frame in flight, registered frame
// capture, bounded wait for bus_ready, and safe-mode restriction to requester 0.
module xrbus_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int FRAME_W  = 4096,
  parameter int MAX_WAIT = 64,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [FRAME_W-1:0] frame_in [0:NUM_REQ-1],
  input  logic               safe_mode,
  input  logic               bus_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    grant_id,
  output logic [FRAME_W-1:0] bus_frame,
  output logic               bus_valid,
  output logic               timeout_err,
  output logic [31:0]        frames_sent,
  output logic [15:0]        drop_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT);

  // Handshake: a frame moves on every edge where bus_valid && bus_ready.
  // bus_valid stays high and bus_frame stays frozen until that edge, a
  // timeout, or a safe-mode abort.
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t              state, state_nx;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     winner;
  logic                win_vld;
  logic [NUM_REQ-1:0]  elig;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                accept, timeout, abort, drop;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_REQ;
    return ID_W'(s);
  endfunction

  // Search starts one past the last served requester so every requester gets a turn.
  always_comb begin
    elig    = safe_mode ? {{(NUM_REQ-1){1'b0}}, req[0]} : req;
    win_vld = 1'b0;
    winner  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!win_vld && elig[rr_idx(last_grant, i)]) begin
        win_vld = 1'b1;
        winner  = rr_idx(last_grant, i);
      end
    end
  end

  assign accept  = (state == XFER) && bus_ready;
  assign timeout = (state == XFER) && !bus_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
  assign abort   = (state == XFER) && !bus_ready && safe_mode && (grant_id != '0);
  assign drop    = timeout || abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win_vld) state_nx = XFER;
      XFER:    if (accept || drop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    bus_valid = 1'b0;
    if (state == XFER) begin
      bus_valid     = 1'b1;
      gnt[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id    <= '0;
      bus_frame   <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      frames_sent <= '0;
      drop_cnt    <= '0;
    end else begin
      timeout_err <= drop;
      if (state == IDLE && win_vld) begin
        grant_id  <= winner;
        bus_frame <= frame_in[winner];
        wait_cnt  <= '0;
      end
      if (state == XFER) begin
        if (accept) begin
          last_grant <= grant_id;
          if (frames_sent != '1) frames_sent <= frames_sent + 32'd1;
        end else if (drop) begin
          last_grant <= grant_id;
          if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_xrbus_tx_arbiter.sv
// Bench for xrbus_tx_arbiter: grant-order vector table, scoreboard of accepted
// frames, and directed timeout / safe-mode / reset sequences.
module tb_xrbus_tx_arbiter;

  localparam int N   = 4;
  localparam int FW  = 64;
  localparam int MW  = 64;
  localparam int IDW = 2;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [FW-1:0] frame_in [0:N-1];
  logic          safe_mode;
  logic          bus_ready;
  logic [N-1:0]  gnt;
  logic [IDW-1:0] grant_id;
  logic [FW-1:0] bus_frame;
  logic          bus_valid;
  logic          timeout_err;
  logic [31:0]   frames_sent;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int fails  = 0;
  int to_seen = 0;
  int exp_sent = 0;
  int exp_drop = 0;

  logic [IDW+FW-1:0] exp_q[$];
  logic [IDW+FW-1:0] sb_e;

  typedef struct {
    logic [N-1:0]   req;
    logic           safe;
    int             hold;
    logic [IDW-1:0] exp_id;
  } vec_t;

  vec_t vecs [8];

  xrbus_tx_arbiter #(.NUM_REQ(N), .FRAME_W(FW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .frame_in(frame_in),
    .safe_mode(safe_mode), .bus_ready(bus_ready), .gnt(gnt),
    .grant_id(grant_id), .bus_frame(bus_frame), .bus_valid(bus_valid),
    .timeout_err(timeout_err), .frames_sent(frames_sent), .drop_cnt(drop_cnt)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a transfer completes on the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (timeout_err) to_seen++;
      check("gnt_onehot", gnt, bus_valid ? (N'(1) << grant_id) : '0);
      if (bus_valid && bus_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", {grant_id, bus_frame}, '0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_xfer", {grant_id, bus_frame}, sb_e);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    logic [FW-1:0] f;
    int n;
    req = v.req;
    safe_mode = v.safe;
    bus_ready = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus_valid && n < 4);
    check({tag, "_valid"}, bus_valid, 1);
    check({tag, "_id"}, grant_id, v.exp_id);
    check({tag, "_gnt"}, gnt, N'(1) << v.exp_id);
    f = frame_in[v.exp_id];
    check({tag, "_frame"}, bus_frame, f);
    exp_q.push_back({v.exp_id, f});
    frame_in[v.exp_id] = ~f;
    req = '0;
    for (int h = 0; h < v.hold; h++) begin
      step();
      check({tag, "_hold_valid"}, bus_valid, 1);
      check({tag, "_hold_frame"}, bus_frame, f);
    end
    bus_ready = 1'b1;
    step();
    exp_sent++;
    check({tag, "_done_valid"}, bus_valid, 0);
    check({tag, "_sent"}, frames_sent, exp_sent);
    bus_ready = 1'b0;
    safe_mode = 1'b0;
  endtask

  initial begin
    int n;
    int tos;
    rst_n = 1'b0;
    req = '0;
    safe_mode = 1'b0;
    bus_ready = 1'b0;
    for (int i = 0; i < N; i++) frame_in[i] = {$urandom(), $urandom()};

    vecs[0] = '{4'b1111, 1'b0, 0,  2'd1};
    vecs[1] = '{4'b1011, 1'b0, 2,  2'd3};
    vecs[2] = '{4'b0110, 1'b0, 1,  2'd1};
    vecs[3] = '{4'b1001, 1'b1, 0,  2'd0};
    vecs[4] = '{4'b0001, 1'b0, 0,  2'd0};
    vecs[5] = '{4'b0100, 1'b0, 10, 2'd2};
    vecs[6] = '{4'b1011, 1'b0, 3,  2'd3};
    vecs[7] = '{4'b1100, 1'b0, 0,  2'd2};

    // Reset state
    step();
    step();
    check("rst_gnt", gnt, 0);
    check("rst_valid", bus_valid, 0);
    check("rst_frame", bus_frame, 0);
    check("rst_id", grant_id, 0);
    check("rst_to", timeout_err, 0);
    check("rst_sent", frames_sent, 0);
    check("rst_drop", drop_cnt, 0);

    // All requesting with bus_ready held high: 0,1,2,3,0 every two cycles
    req = 4'b1111;
    bus_ready = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back({IDW'(k % N), frame_in[k % N]});
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_id", grant_id, k % N);
      check("rr_gnt", gnt, N'(1) << (k % N));
      if (k < 4) begin
        step();
        exp_sent++;
        check("rr_gap_valid", bus_valid, 0);
      end
    end
    check("rr_sent4", frames_sent, 4);
    req = '0;
    step();
    exp_sent++;
    check("rr_sent5", frames_sent, exp_sent);

    // bus_ready while idle is ignored and pointer stays put
    repeat (3) step();
    check("idle_ready_sent", frames_sent, exp_sent);
    check("idle_ready_valid", bus_valid, 0);
    bus_ready = 1'b0;

    frame_in[2] = {8{8'hA5}};
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    check("vec_no_timeout", to_seen, 0);

    // Timeout after MAX_WAIT cycles, then regrant to requester 1
    req = 4'b0010;
    step();
    check("to_grant_id", grant_id, 1);
    tos = to_seen;
    n = 0;
    while (!timeout_err && n < 100) begin
      step();
      n++;
    end
    check("to_cycles", n, MW);
    check("to_valid", bus_valid, 0);
    exp_drop++;
    check("to_drop", drop_cnt, exp_drop);
    check("to_sent", frames_sent, exp_sent);
    step();
    check("to_pulse_end", timeout_err, 0);
    check("to_regrant_valid", bus_valid, 1);
    check("to_regrant_id", grant_id, 1);
    check("to_pulse_count", to_seen - tos, 1);
    exp_q.push_back({2'd1, frame_in[1]});
    bus_ready = 1'b1;
    req = '0;
    step();
    exp_sent++;
    bus_ready = 1'b0;
    check("to_regrant_sent", frames_sent, exp_sent);

    // Safe mode aborts requester 3, then only requester 0 is served
    req = 4'b1000;
    step();
    check("sm_grant_id", grant_id, 3);
    step();
    step();
    safe_mode = 1'b1;
    req = 4'b1001;
    step();
    check("sm_abort_to", timeout_err, 1);
    check("sm_abort_valid", bus_valid, 0);
    exp_drop++;
    check("sm_abort_drop", drop_cnt, exp_drop);
    step();
    check("sm_g0_id", grant_id, 0);
    check("sm_g0_gnt", gnt, 4'b0001);
    exp_q.push_back({2'd0, frame_in[0]});
    bus_ready = 1'b1;
    step();
    exp_sent++;
    exp_q.push_back({2'd0, frame_in[0]});
    step();
    check("sm_g0b_id", grant_id, 0);
    check("sm_g0b_valid", bus_valid, 1);
    step();
    exp_sent++;
    req = '0;
    safe_mode = 1'b0;
    bus_ready = 1'b0;
    check("sm_sent", frames_sent, exp_sent);
    check("sm_drop_final", drop_cnt, exp_drop);

    // bus_ready on the final wait cycle wins over the timeout
    req = 4'b0100;
    step();
    check("co_grant_id", grant_id, 2);
    req = '0;
    tos = to_seen;
    repeat (MW - 1) step();
    check("co_still_valid", bus_valid, 1);
    check("co_no_to_yet", timeout_err, 0);
    exp_q.push_back({2'd2, bus_frame});
    bus_ready = 1'b1;
    step();
    exp_sent++;
    check("co_sent", frames_sent, exp_sent);
    check("co_drop", drop_cnt, exp_drop);
    check("co_to", timeout_err, 0);
    check("co_valid", bus_valid, 0);
    step();
    check("co_to_after", timeout_err, 0);
    check("co_to_count", to_seen - tos, 0);
    bus_ready = 1'b0;

    // Reset mid-transfer clears everything at once; requester 1 wins first afterwards
    req = 4'b1000;
    step();
    check("rx_grant_id", grant_id, 3);
    step();
    rst_n = 1'b0;
    #1;
    check("rx_gnt", gnt, 0);
    check("rx_valid", bus_valid, 0);
    check("rx_frame", bus_frame, 0);
    check("rx_id", grant_id, 0);
    check("rx_to", timeout_err, 0);
    check("rx_sent", frames_sent, 0);
    check("rx_drop", drop_cnt, 0);
    exp_sent = 0;
    req = 4'b1010;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rx_first_id", grant_id, 1);
    check("rx_first_gnt", gnt, 4'b0010);
    exp_q.push_back({2'd1, frame_in[1]});
    bus_ready = 1'b1;
    req = '0;
    step();
    exp_sent++;
    bus_ready = 1'b0;
    check("rx_sent_after", frames_sent, exp_sent);
    check("rx_drop_after", drop_cnt, 0);

    step();
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
